cpu_core_p: RTL and testbench
=============================

Name: cpu_core_p

Overview:
Parametrised multi-cycle 16-bit-ISA CPU core. It combines an instruction register, decode, a control FSM, an 8-entry register file, a shifter, an ALU and status flags in one block.
- Generalises the previous core to datapath width DW.
- New behaviour: IR load locked out while busy, same-cycle load+start bypass, illegal-opcode detection, register-file clear on reset, signed-correct V flag, and a debug read port.
- Sits below the lab top level. Instructions arrive on `in` from switches or a future fetch unit.

Parameters:
- DW, 16, datapath/register width; must be >= 16.
- IR_W, 16, instruction width; fixed encoding, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- s  input  1  start request; sampled only in WAIT.
- load  input  1  load `in` into the IR; honoured only while w=1.
- in  input  16  instruction word.
- dbg_addr  input  3  debug register index.
- out  output  DW  C register (last ALU-path result).
- N  output  1  negative flag.
- V  output  1  signed-overflow flag.
- Z  output  1  zero flag.
- w  output  1  idle/waiting; 1 in WAIT.
- illegal  output  1  one-cycle pulse on an undecodable instruction.
- dbg_data  output  DW  combinational read of R[dbg_addr].

Behaviour:
- Reset (reset=0, asynchronous):
  - State WAIT; w=1; out=0; N=V=Z=0; illegal=0; IR=0; R0..R7=0.
  - Assertion mid-instruction aborts it. No register, C or flag update completes.
- Encoding: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
  - sximm8 = imm8 sign-extended to DW.
- Shifter on B (sh): 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB replicated).
- Instructions:
  - 110/10 MOV Rn,#imm8 → Rn=sximm8.
  - 110/00 MOV Rd,Rm,sh → Rd=sh(Rm), with A forced to 0.
  - 101/00 ADD → Rd=Rn+sh(Rm).
  - 101/01 CMP → flags from Rn−sh(Rm), no register write.
  - 101/10 AND → Rd=Rn&sh(Rm).
  - 101/11 MVN → Rd=~sh(Rm).
  - Any other opcode/op pair is illegal.
- Arithmetic: all results are modulo 2^DW.
- Flags: updated only at CMP's CALC edge.
  - N = result[DW−1]; Z = (result==0).
  - V = signed overflow of the subtraction: (Rn[msb]≠B[msb]) && (res[msb]≠Rn[msb]).
- C register (`out`): loaded at the CALC edge of every ALU-path instruction, CMP included. MOV imm and illegal instructions leave it unchanged.
- FSM states: WAIT, DECODE, GETA, GETB, CALC, WRITE, WIMM.
  - WAIT –s→ DECODE. w falls in the same cycle DECODE is entered.
  - DECODE:
    - MOV imm → WIMM → WAIT.
    - MOV reg → GETB.
    - ADD/AND/CMP → GETA → GETB.
    - MVN → GETB.
    - illegal → WAIT, with illegal=1 for the DECODE cycle.
  - GETB → CALC.
  - CALC → WRITE, or → WAIT for CMP.
  - WRITE → WAIT.
- Cycles with w=0, measured from the start edge:
  - ADD/AND: 5.
  - MVN / MOV reg: 4.
  - CMP: 4.
  - MOV imm: 2.
  - illegal: 1.
- Register write: the register-file write occurs on the edge leaving WRITE/WIMM. It is visible on dbg_data the following cycle.
- IR rules:
  - IR loads on load=1 && w=1.
  - load while w=0 is ignored, so the IR is stable through execution.
  - load=1 && s=1 in the same WAIT cycle: the instruction executed is `in` (bypass), and the IR captures it too.
- s while w=0 is ignored (no queueing). s held high in WAIT restarts immediately after completion.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode/op localparams;
  - shift codes 2'b00..2'b11;
  - FSM state encoding (3-bit enum);
  - field bit-position constants.
- Sub-module cpu_regfile(DW): 8×DW, one synchronous write port, two combinational read ports plus a debug read port, asynchronous active-low clear.
- FSM, decode, shifter and ALU remain in cpu_core_p.

Test Plan:
1. Hold reset=0, then release → w=1, out=0, N=V=Z=0; dbg_data=0 for all dbg_addr 0..7.
2. Load 0xD007 with s → w=0 for exactly 2 cycles, R0=7, out stays 0. Then 0xD1FE → R1=0xFFFE.
3. ADD R2,R1,R0,LSL#1 (0xA148) → w=0 for 5 cycles, out=0x000C, R2=0x000C, flags unchanged (0).
4. CMP R0,R1 (0xA801) → N=0, Z=0, V=0, out=0x0009. Then run in sequence:
   - 0xD400 → R4=0;
   - MVN 0xB8A4 → R5=0xFFFF;
   - MOV R6,R5,LSR#1 (0xC0D5) → R6=0x7FFF;
   - CMP 0xAE01 → V=1, N=1, Z=0, out=0x8001.
5. Load 0xE000 with s → illegal=1 for one cycle, w=0 for 1 cycle, registers/out/flags unchanged.
   - load of 0xD0FF pulsed during a busy ADD → IR unchanged and R0 not modified.
   - s+load in the same WAIT cycle executes the new word.
6. Drive reset=0 asynchronously while in GETB of an ADD → w=1 immediately (no clock), out=0, all registers 0. After release, restart proceeds normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_core_p multi-cycle core: opcodes, shift codes,
// FSM states, instruction field positions and the instruction classifier.
package cpu_pkg;

   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_ALU    = 3'b101;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam int OPC_LSB = 13;
   localparam int OP_LSB  = 11;
   localparam int RN_LSB  = 8;
   localparam int RD_LSB  = 5;
   localparam int SH_LSB  = 3;
   localparam int RM_LSB  = 0;
   localparam int IMM_W   = 8;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_CALC   = 3'd4,
      S_WRITE  = 3'd5,
      S_WIMM   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      K_ILLEGAL, K_MOV_IMM, K_MOV_REG, K_ADD, K_CMP, K_AND, K_MVN
   } kind_t;

   function automatic kind_t decode_kind(input logic [15:0] ir);
      logic [2:0] opc;
      logic [1:0] op;
      opc = ir[OPC_LSB +: 3];
      op  = ir[OP_LSB +: 2];
      decode_kind = K_ILLEGAL;
      if (opc == OPC_MOV && op == OP_MOV_IMM) begin
         decode_kind = K_MOV_IMM;
      end else if (opc == OPC_MOV && op == OP_MOV_REG) begin
         decode_kind = K_MOV_REG;
      end else if (opc == OPC_ALU) begin
         case (op)
            OP_ADD:  decode_kind = K_ADD;
            OP_CMP:  decode_kind = K_CMP;
            OP_AND:  decode_kind = K_AND;
            OP_MVN:  decode_kind = K_MVN;
            default: decode_kind = K_ILLEGAL;
         endcase
      end
   endfunction

endpackage

// File: rtl/cpu_core_p_if.sv
// Instruction/start, status and debug signals of cpu_core_p bundled as one port.
interface cpu_core_p_if #(parameter int DW = 16);
   import cpu_pkg::*;

   // Handshake: s is a start request accepted only on an edge where w=1; w=0
   // marks the core busy, and a request or load seen while busy is dropped.
   logic          s;
   logic          load;
   logic [15:0]   in;
   logic [2:0]    dbg_addr;
   logic [DW-1:0] out;
   logic          N;
   logic          V;
   logic          Z;
   logic          w;
   logic          illegal;
   logic [DW-1:0] dbg_data;
   state_t        dbg_state;

   modport master (
      output s, load, in, dbg_addr,
      input  out, N, V, Z, w, illegal, dbg_data, dbg_state
   );

   modport slave (
      input  s, load, in, dbg_addr,
      output out, N, V, Z, w, illegal, dbg_data, dbg_state
   );

endinterface

// File: rtl/cpu_regfile.sv
// Eight-entry register file: one synchronous write port, two combinational
// operand reads and a combinational debug read, cleared by reset.
module cpu_regfile #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [2:0]    waddr,
   input  logic [DW-1:0] wdata,
   input  logic [2:0]    raddr_a,
   input  logic [2:0]    raddr_b,
   input  logic [2:0]    dbg_addr,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] regs_q [8];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata_a  = regs_q[raddr_a];
   assign rdata_b  = regs_q[raddr_b];
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle 16-bit-ISA core with DW-wide datapath: instruction register,
// decode, control FSM, shifter, ALU, status flags and the register file.
module cpu_core_p
   import cpu_pkg::*;
#(
   parameter int DW   = 16,
   parameter int IR_W = 16
) (
   input logic         clk,
   input logic         reset,
   cpu_core_p_if.slave bus
);

   state_t          state_q;
   logic            w_q, illegal_q;
   logic [IR_W-1:0] ir_q, ir_d, instr;
   kind_t           kind;
   logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic            n_q, n_d, v_q, v_d, z_q, z_d;
   logic [2:0]      rn, rd, rm;
   logic [1:0]      sh;
   logic [DW-1:0]   sximm8, rd_a, rd_b, b_sh, alu_res;
   logic            rf_we;
   logic [2:0]      rf_waddr;
   logic [DW-1:0]   rf_wdata;

   // While idle, a word on `in` with load=1 is both captured and executed.
   always_comb begin
      ir_d = ir_q;
      if (w_q && bus.load) ir_d = bus.in;
   end

   assign instr  = ir_d;
   assign kind   = decode_kind(instr);
   assign rn     = instr[RN_LSB +: 3];
   assign rd     = instr[RD_LSB +: 3];
   assign rm     = instr[RM_LSB +: 3];
   assign sh     = instr[SH_LSB +: 2];
   assign sximm8 = {{(DW-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

   always_comb begin
      case (sh)
         SH_NONE: b_sh = b_q;
         SH_LSL:  b_sh = {b_q[DW-2:0], 1'b0};
         SH_LSR:  b_sh = {1'b0, b_q[DW-1:1]};
         SH_ASR:  b_sh = {b_q[DW-1], b_q[DW-1:1]};
         default: b_sh = b_q;
      endcase
   end

   always_comb begin
      case (kind)
         K_ADD:   alu_res = a_q + b_sh;
         K_CMP:   alu_res = a_q - b_sh;
         K_AND:   alu_res = a_q & b_sh;
         K_MVN:   alu_res = ~b_sh;
         default: alu_res = a_q + b_sh; // MOV reg: A was cleared in DECODE
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      n_d      = n_q;
      v_d      = v_q;
      z_d      = z_q;
      rf_we    = 1'b0;
      rf_waddr = rd;
      rf_wdata = c_q;
      case (state_q)
         S_DECODE: a_d = '0;
         S_GETA:   a_d = rd_a;
         S_GETB:   b_d = rd_b;
         S_CALC: begin
            c_d = alu_res;
            if (kind == K_CMP) begin
               n_d = alu_res[DW-1];
               z_d = (alu_res == '0);
               v_d = (a_q[DW-1] != b_sh[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
         end
         S_WRITE:  rf_we = 1'b1;
         S_WIMM: begin
            rf_we    = 1'b1;
            rf_waddr = rn;
            rf_wdata = sximm8;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= '0;
         n_q  <= 1'b0;
         v_q  <= 1'b0;
         z_q  <= 1'b0;
      end else begin
         ir_q <= ir_d;
         a_q  <= a_d;
         b_q  <= b_d;
         c_q  <= c_d;
         n_q  <= n_d;
         v_q  <= v_d;
         z_q  <= z_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_WAIT;
         w_q       <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            S_WAIT: begin
               if (bus.s) begin
                  state_q   <= S_DECODE;
                  w_q       <= 1'b0;
                  illegal_q <= (kind == K_ILLEGAL);
               end
            end
            S_DECODE: begin
               case (kind)
                  K_MOV_IMM:           state_q <= S_WIMM;
                  K_MOV_REG, K_MVN:    state_q <= S_GETB;
                  K_ADD, K_AND, K_CMP: state_q <= S_GETA;
                  default: begin
                     state_q <= S_WAIT;
                     w_q     <= 1'b1;
                  end
               endcase
            end
            S_GETA: state_q <= S_GETB;
            S_GETB: state_q <= S_CALC;
            S_CALC: begin
               if (kind == K_CMP) begin
                  state_q <= S_WAIT;
                  w_q     <= 1'b1;
               end else begin
                  state_q <= S_WRITE;
               end
            end
            default: begin
               state_q <= S_WAIT;
               w_q     <= 1'b1;
            end
         endcase
      end
   end

   cpu_regfile #(.DW(DW)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr_a  (rn),
      .raddr_b  (rm),
      .dbg_addr (bus.dbg_addr),
      .rdata_a  (rd_a),
      .rdata_b  (rd_b),
      .dbg_data (bus.dbg_data)
   );

   assign bus.out       = c_q;
   assign bus.N         = n_q;
   assign bus.V         = v_q;
   assign bus.Z         = z_q;
   assign bus.w         = w_q;
   assign bus.illegal   = illegal_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: a driver issues instructions and pushes the model's
// expected architectural state; a monitor pops it at every completion.
module tb_cpu_core_p;

   localparam int DW = 16;

   typedef struct packed {
      logic [15:0]      out;
      logic             n;
      logic             v;
      logic             z;
      logic [3:0]       cycles;
      logic             ill;
      logic [7:0][15:0] regs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   logic [15:0] m_r [8];
   logic [15:0] m_c, m_ir;
   logic        m_n, m_v, m_z;

   cpu_core_p_if #(.DW(DW)) bus ();

   cpu_core_p #(.DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
      logic signed [15:0] sb;
      sb = b;
      case (sh)
         2'd1:    return b << 1;
         2'd2:    return b >> 1;
         2'd3:    return sb >>> 1;
         default: return b;
      endcase
   endfunction

   task automatic push_exp(input int cyc, input logic ill);
      exp_t e;
      e.out    = m_c;
      e.n      = m_n;
      e.v      = m_v;
      e.z      = m_z;
      e.cycles = 4'(cyc);
      e.ill    = ill;
      for (int i = 0; i < 8; i++) e.regs[i] = m_r[i];
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_c  = 16'h0;
      m_ir = 16'h0;
      m_n  = 1'b0;
      m_v  = 1'b0;
      m_z  = 1'b0;
      push_exp(0, 1'b0);
   endtask

   task automatic model_exec(input logic [15:0] word);
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh;
      logic [15:0] a, b;
      int          d, cyc;
      logic        ill;
      opc = word[15:13];
      op  = word[12:11];
      rn  = word[10:8];
      rd  = word[7:5];
      sh  = word[4:3];
      rm  = word[2:0];
      a   = m_r[rn];
      b   = shf(m_r[rm], sh);
      cyc = 1;
      ill = 1'b0;
      if (opc == 3'b110 && op == 2'b10) begin
         m_r[rn] = {{8{word[7]}}, word[7:0]};
         cyc = 2;
      end else if (opc == 3'b110 && op == 2'b00) begin
         m_c = b;
         m_r[rd] = b;
         cyc = 4;
      end else if (opc == 3'b101) begin
         case (op)
            2'b00: begin m_c = a + b; m_r[rd] = m_c; cyc = 5; end
            2'b01: begin
               m_c = a - b;
               d   = int'($signed(a)) - int'($signed(b));
               m_n = m_c[15];
               m_z = (m_c == 16'h0);
               m_v = (d > 32767) || (d < -32768);
               cyc = 4;
            end
            2'b10: begin m_c = a & b; m_r[rd] = m_c; cyc = 5; end
            default: begin m_c = ~b; m_r[rd] = m_c; cyc = 4; end
         endcase
      end else begin
         ill = 1'b1;
      end
      push_exp(cyc, ill);
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] wd;
      wd = 16'($urandom);
      case ($urandom_range(0, 9))
         0, 1, 2:    wd[15:11] = 5'b11010;
         3:          wd[15:11] = 5'b11000;
         4, 5, 6, 7: wd[15:13] = 3'b101;
         default: ;
      endcase
      return wd;
   endfunction

   // ---------------- driver ----------------
   // mode 0: load then start; mode 1: load+start together; mode 2: start only.
   task automatic issue(input logic [15:0] word, input int mode);
      int          guard;
      logic [15:0] x;
      @(negedge clk);
      x = word;
      if (mode == 0) begin
         bus.in   = word;
         bus.load = 1'b1;
         m_ir     = word;
         @(negedge clk);
         bus.load = 1'b0;
         bus.in   = 16'($urandom);
      end else if (mode == 1) begin
         bus.in   = word;
         bus.load = 1'b1;
         m_ir     = word;
      end else begin
         x        = m_ir;
         bus.load = 1'b0;
         bus.in   = 16'($urandom);
      end
      bus.s = 1'b1;
      model_exec(x);
      @(negedge clk);
      bus.s    = 1'b0;
      bus.load = 1'b0;
      guard    = 0;
      while (!bus.w && guard < 12) begin
         if ($urandom_range(0, 2) == 0) begin
            bus.load = 1'b1;
            bus.s    = 1'($urandom_range(0, 1));
            bus.in   = ($urandom_range(0, 1) == 1) ? 16'hD0FF : 16'($urandom);
         end else begin
            bus.load = 1'b0;
            bus.s    = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      bus.load = 1'b0;
      bus.s    = 1'b0;
      chk("completion_timeout", {31'h0, bus.w}, 32'h1);
   endtask

   task automatic abort_add();
      @(negedge clk);
      bus.in   = 16'hA148;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      @(negedge clk);
      bus.s    = 1'b0;
      bus.load = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      model_reset();
      reset = 1'b0;
      #1;
      chk("async_reset_w", {31'h0, bus.w}, 32'h1);
      chk("async_reset_out", {16'h0, bus.out}, 32'h0);
      chk("async_reset_flags", {29'h0, bus.N, bus.V, bus.Z}, 32'h0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin : driver
      bus.s    = 1'b0;
      bus.load = 1'b0;
      bus.in   = 16'h0;
      reset    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;

      issue(16'hD007, 0);
      issue(16'hD1FE, 0);
      issue(16'hA148, 0);
      issue(16'hA801, 0);
      issue(16'hD400, 0);
      issue(16'hB8A4, 0);
      issue(16'hC0D5, 0);
      issue(16'hAE01, 0);
      issue(16'hE000, 0);
      issue(16'hA148, 1);
      issue(16'h0000, 2);
      issue(16'hD305, 1);

      abort_add();
      issue(16'hD007, 1);
      issue(16'hD1FE, 0);
      issue(16'hA148, 0);

      repeat (60) issue(rand_word(), int'($urandom_range(0, 2)));

      repeat (4) @(negedge clk);
      chk("pending_expectations", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- monitor ----------------
   task automatic check_item(input int busy, input int ill);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_completion", 32'h1, 32'h0);
         return;
      end
      e = exp_q.pop_front();
      chk("out", {16'h0, bus.out}, {16'h0, e.out});
      chk("flag_n", {31'h0, bus.N}, {31'h0, e.n});
      chk("flag_v", {31'h0, bus.V}, {31'h0, e.v});
      chk("flag_z", {31'h0, bus.Z}, {31'h0, e.z});
      chk("busy_cycles", busy, {28'h0, e.cycles});
      chk("illegal_pulses", ill, {31'h0, e.ill});
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         chk($sformatf("reg_r%0d", i), {16'h0, bus.dbg_data}, {16'h0, e.regs[i]});
      end
   endtask

   initial begin : monitor
      int   busy, ill;
      logic prev_w;
      busy         = 0;
      ill          = 0;
      prev_w       = 1'b1;
      bus.dbg_addr = 3'd0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            while (!reset) @(negedge clk);
            check_item(0, 0);
            busy   = 0;
            ill    = 0;
            prev_w = 1'b1;
         end else if (!bus.w) begin
            busy++;
            if (bus.illegal) ill++;
            prev_w = 1'b0;
         end else begin
            if (!prev_w) begin
               check_item(busy, ill);
               busy = 0;
               ill  = 0;
            end
            prev_w = 1'b1;
         end
      end
   end

endmodule
